// File: rtl/regfile_bist.sv
// regfile_bist: built-in self-test controller for a 2^ADDR_BITS-entry register file.
// It writes an address pattern and then its inverse to every register. After
// each write pass it reads every register back on both read ports. It counts
// mismatching port reads with a saturating counter, records the first failing
// register, and reports pass/fail when the test completes.
module regfile_bist #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] read_reg1,
  output logic [ADDR_BITS-1:0] read_reg2,
  output logic [ADDR_BITS-1:0] write_reg,
  output logic                 write_enable,
  output logic [WIDTH-1:0]     write_data,
  input  logic [WIDTH-1:0]     read_data1,
  input  logic [WIDTH-1:0]     read_data2,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic [ADDR_BITS-1:0] first_fail_reg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE0 = 3'd1,
    S_READ0  = 3'd2,
    S_WRITE1 = 3'd3,
    S_READ1  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;

  // Port-facing registers. Their next values are derived from the next state,
  // so the outputs are glitch-free and line up with the state they belong to.
  logic                 write_enable_q, write_enable_d;
  logic [ADDR_BITS-1:0] write_reg_q, write_reg_d;
  logic [WIDTH-1:0]     write_data_q, write_data_d;
  logic [ADDR_BITS-1:0] read_reg1_q, read_reg1_d;
  logic [ADDR_BITS-1:0] read_reg2_q, read_reg2_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Result registers.
  logic                 pass_q, pass_d;
  logic [CNT_WIDTH-1:0] fail_count_q, fail_count_d;
  logic [ADDR_BITS-1:0] first_fail_q, first_fail_d;

  // Compare path.
  logic                 in_read_q;
  logic                 invert_q;
  logic                 mis1, mis2;
  logic [CNT_WIDTH:0]   cnt_sum;

  // P0(a) is the zero-extended address; P1(a) is its bitwise inverse.
  function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_BITS-1:0] addr,
                                               input logic invert);
    logic [WIDTH-1:0] p;
    p = '0;
    p[ADDR_BITS-1:0] = addr;
    return invert ? ~p : p;
  endfunction

  // Register 0 is hardwired to zero, so it must read 0 whatever was written.
  function automatic logic [WIDTH-1:0] expected(input logic [ADDR_BITS-1:0] addr,
                                                input logic invert);
    return (addr == '0) ? '0 : pattern(addr, invert);
  endfunction

  // Next-state logic: each phase sweeps the index once, then moves to the next phase.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE0;
          idx_d   = '0;
        end
      end
      S_WRITE0, S_READ0, S_WRITE1, S_READ1: begin
        idx_d = idx_q + 1'b1;  // wraps to 0 after LAST_IDX
        if (idx_q == LAST_IDX) begin
          case (state_q)
            S_WRITE0: state_d = S_READ0;
            S_READ0:  state_d = S_WRITE1;
            S_WRITE1: state_d = S_READ1;
            default:  state_d = S_DONE;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port outputs for the coming cycle. Addresses and data hold outside their phases.
  always_comb begin
    write_enable_d = (state_d == S_WRITE0) || (state_d == S_WRITE1);
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    read_reg1_d    = read_reg1_q;
    read_reg2_d    = read_reg2_q;
    busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d         = (state_d == S_DONE);
    if (write_enable_d) begin
      write_reg_d  = idx_d;
      write_data_d = pattern(idx_d, state_d == S_WRITE1);
    end
    if ((state_d == S_READ0) || (state_d == S_READ1)) begin
      read_reg1_d = idx_d;
      read_reg2_d = ~idx_d;  // N-1-i
    end
  end

  // Compare both ports against the expected value for the current read phase.
  always_comb begin
    in_read_q = (state_q == S_READ0) || (state_q == S_READ1);
    invert_q  = (state_q == S_READ1);
    mis1      = in_read_q && (read_data1 != expected(read_reg1_q, invert_q));
    mis2      = in_read_q && (read_data2 != expected(read_reg2_q, invert_q));
    cnt_sum   = {1'b0, fail_count_q} + (CNT_WIDTH + 1)'(mis1) + (CNT_WIDTH + 1)'(mis2);
  end

  // Result update: cleared on an accepted start, accumulated in reads, pass decided in DONE.
  always_comb begin
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    if ((state_q == S_IDLE) && start) begin
      pass_d       = 1'b0;
      fail_count_d = '0;
      first_fail_d = '0;
    end else if (in_read_q) begin
      fail_count_d = (cnt_sum > {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
      // The count never returns to zero, so zero means no mismatch has been seen yet.
      if ((fail_count_q == '0) && (mis1 || mis2)) begin
        first_fail_d = mis1 ? read_reg1_q : read_reg2_q;
      end
    end else if (state_q == S_DONE) begin
      pass_d = (fail_count_q == '0);
    end
  end

  // State and index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Port output registers; reset drops write_enable immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable_q <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      read_reg1_q    <= '0;
      read_reg2_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      write_enable_q <= write_enable_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      read_reg1_q    <= read_reg1_d;
      read_reg2_q    <= read_reg2_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Result registers; reset discards any partial results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_q       <= 1'b0;
      fail_count_q <= '0;
      first_fail_q <= '0;
    end else begin
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign write_enable   = write_enable_q;
  assign write_reg      = write_reg_q;
  assign write_data     = write_data_q;
  assign read_reg1      = read_reg1_q;
  assign read_reg2      = read_reg2_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_count_q;
  assign first_fail_reg = first_fail_q;

endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: runs the BIST against a behavioural register file with
// selectable faults. A second instance (CNT_WIDTH=6) reads a constant value.
module tb_regfile_bist;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start6 = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (defaults)
  logic [4:0]  rr1, rr2, wr, ffr;
  logic        we, busy, done, pass;
  logic [31:0] wd, rd1, rd2;
  logic [7:0]  cnt;

  // Saturation DUT (CNT_WIDTH=6)
  logic [4:0]  rr1_6, rr2_6, wr_6, ffr_6;
  logic        we_6, busy_6, done_6, pass_6;
  logic [31:0] wd_6;
  logic [5:0]  cnt_6;
  logic [31:0] const_data = 32'h1234_5678;

  regfile_bist dut (
    .clk(clk), .reset(reset), .start(start),
    .read_reg1(rr1), .read_reg2(rr2), .write_reg(wr), .write_enable(we), .write_data(wd),
    .read_data1(rd1), .read_data2(rd2),
    .busy(busy), .done(done), .pass(pass), .fail_count(cnt), .first_fail_reg(ffr)
  );

  regfile_bist #(.WIDTH(32), .ADDR_BITS(5), .CNT_WIDTH(6)) dut6 (
    .clk(clk), .reset(reset), .start(start6),
    .read_reg1(rr1_6), .read_reg2(rr2_6), .write_reg(wr_6), .write_enable(we_6), .write_data(wd_6),
    .read_data1(const_data), .read_data2(const_data),
    .busy(busy_6), .done(done_6), .pass(pass_6), .fail_count(cnt_6), .first_fail_reg(ffr_6)
  );

  // Behavioural register file. mode: 0 good, 1 reg5 bit0 stuck-at-0,
  // 2 writable x0, 3 constant 0x12345678, 4 regs 10 and 21 bit31 stuck-at-1.
  int          mode = 0;
  logic [31:0] regs [32];
  logic [31:0] wval;

  always @(posedge clk) begin
    if (we) begin
      wval = wd;
      if (mode == 1 && wr == 5'd5) wval[0] = 1'b0;
      if (mode == 4 && (wr == 5'd10 || wr == 5'd21)) wval[31] = 1'b1;
      regs[wr] <= wval;
    end
  end

  always_comb begin
    rd1 = regs[rr1];
    rd2 = regs[rr2];
    if (mode != 2 && rr1 == 5'd0) rd1 = 32'd0;
    if (mode != 2 && rr2 == 5'd0) rd2 = 32'd0;
    if (mode == 3) begin
      rd1 = 32'h1234_5678;
      rd2 = 32'h1234_5678;
    end
  end

  // Scoreboard of expected final results, pushed when a test is started.
  typedef struct packed {
    logic       pass;
    logic [7:0] cnt;
    logic [4:0] ffr;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int tests = 0;
  int fails = 0;

  // Observations from the most recent run
  int         done_cycle, busy_cycles, done_pulses;
  logic [7:0] cnt_c1;
  logic       pass_c1;

  // Pulse start (called at a negedge); cycle 1 is the cycle after the sampling edge.
  // Returns at the negedge of the cycle after done (back in IDLE).
  task automatic run_and_wait(input int extra_start);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt_c1 = cnt;
    pass_c1 = pass;
    done_cycle = 0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_cycle == 0) done_cycle = c;
      end
      start = (c == extra_start);
      if (done_cycle != 0 && c > done_cycle) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({we, busy, done, pass, cnt, ffr, rr1, rr2, wr, wd} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want all zero", {we, busy, done, pass, cnt, ffr, rr1, rr2, wr, wd});
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({we, busy, done, pass, cnt_6} !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: got %h, want 0", {we, busy, done, pass, cnt_6});
    end
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_good();
    mode = 0;
    sb.push_back('{pass: 1'b1, cnt: 8'd0, ffr: 5'd0});
    run_and_wait(0);
    e = sb.pop_front();
    tests++;
    if (done_cycle !== 129) begin fails++; $display("FAIL good_done_cycle: got %0d, want 129", done_cycle); end
    tests++;
    if (done_pulses !== 1) begin fails++; $display("FAIL good_done_width: got %0d, want 1", done_pulses); end
    tests++;
    if (busy_cycles !== 128) begin fails++; $display("FAIL good_busy_cycles: got %0d, want 128", busy_cycles); end
    tests++;
    if ({pass, cnt, ffr} !== e) begin
      fails++;
      $display("FAIL good_result: got pass=%0d cnt=%0d ffr=%0d, want pass=%0d cnt=%0d ffr=%0d", pass, cnt, ffr, e.pass, e.cnt, e.ffr);
    end
    $display("[TB] good regfile: done at cycle %0d pass=%0d cnt=%0d", done_cycle, pass, cnt);
  endtask

  task automatic test_fault(input int m, input logic [7:0] ecnt, input logic [4:0] effr);
    mode = m;
    sb.push_back('{pass: 1'b0, cnt: ecnt, ffr: effr});
    run_and_wait(0);
    e = sb.pop_front();
    tests++;
    if (done_cycle !== 129) begin fails++; $display("FAIL fault%0d_done_cycle: got %0d, want 129", m, done_cycle); end
    tests++;
    if ({pass, cnt, ffr} !== e) begin
      fails++;
      $display("FAIL fault%0d_result: got pass=%0d cnt=%0d ffr=%0d, want pass=%0d cnt=%0d ffr=%0d", m, pass, cnt, ffr, e.pass, e.cnt, e.ffr);
    end
    $display("[TB] fault mode %0d: pass=%0d cnt=%0d ffr=%0d", m, pass, cnt, ffr);
  endtask

  task automatic test_ignored_start();
    mode = 0;
    sb.push_back('{pass: 1'b1, cnt: 8'd0, ffr: 5'd0});
    run_and_wait(40);
    e = sb.pop_front();
    tests++;
    if ({pass_c1, cnt_c1} !== 9'd0) begin
      fails++;
      $display("FAIL start_clears: got pass=%0d cnt=%0d, want 0 0", pass_c1, cnt_c1);
    end
    tests++;
    if (done_cycle !== 129) begin fails++; $display("FAIL ignored_start_done: got %0d, want 129", done_cycle); end
    tests++;
    if ({pass, cnt, ffr} !== e) begin
      fails++;
      $display("FAIL ignored_start_result: got pass=%0d cnt=%0d ffr=%0d, want pass=%0d cnt=%0d ffr=%0d", pass, cnt, ffr, e.pass, e.cnt, e.ffr);
    end
    $display("[TB] start at cycle 40 ignored: done at cycle %0d", done_cycle);
  endtask

  task automatic test_saturate();
    int dc;
    sb.push_back('{pass: 1'b0, cnt: 8'd63, ffr: 5'd0});
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    dc = 0;
    for (int c = 1; c <= 200; c++) begin
      if (done_6) begin dc = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (dc !== 129) begin fails++; $display("FAIL sat_done_cycle: got %0d, want 129", dc); end
    tests++;
    if ({pass_6, 2'b00, cnt_6} !== {e.pass, e.cnt}) begin
      fails++;
      $display("FAIL sat_result: got pass=%0d cnt=%0d, want pass=%0d cnt=%0d", pass_6, cnt_6, e.pass, e.cnt);
    end
    $display("[TB] saturation: cnt=%0d pass=%0d", cnt_6, pass_6);
  endtask

  task automatic test_reset_mid();
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (73) @(negedge clk);  // now in cycle 74, inside WRITE1
    tests++;
    if ({we, busy, cnt} !== {1'b1, 1'b1, 8'd2}) begin
      fails++;
      $display("FAIL mid_write1: got we=%0d busy=%0d cnt=%0d, want 1 1 2", we, busy, cnt);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (we !== 1'b0) begin fails++; $display("FAIL async_we_drop: got %0d, want 0", we); end
    tests++;
    if ({busy, done, pass, cnt, ffr, rr1, rr2, wr, wd} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %h, want all zero", {busy, done, pass, cnt, ffr, rr1, rr2, wr, wd});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({we, busy} !== 2'b00) begin fails++; $display("FAIL idle_after_mid_reset: got %b, want 00", {we, busy}); end
    mode = 0;
    sb.push_back('{pass: 1'b1, cnt: 8'd0, ffr: 5'd0});
    run_and_wait(0);
    e = sb.pop_front();
    tests++;
    if (done_cycle !== 129 || busy_cycles !== 128) begin
      fails++;
      $display("FAIL rerun_timing: got done=%0d busy=%0d, want 129 128", done_cycle, busy_cycles);
    end
    tests++;
    if ({pass, cnt, ffr} !== e) begin
      fails++;
      $display("FAIL rerun_result: got pass=%0d cnt=%0d ffr=%0d, want pass=%0d cnt=%0d ffr=%0d", pass, cnt, ffr, e.pass, e.cnt, e.ffr);
    end
    $display("[TB] reset mid-WRITE1 then rerun: done at cycle %0d pass=%0d", done_cycle, pass);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;
    test_reset();
    test_good();
    test_fault(1, 8'd2, 5'd5);    // reg 5 bit 0 stuck at 0
    test_fault(2, 8'd2, 5'd0);    // writable x0
    test_fault(4, 8'd4, 5'd10);   // both ports fail in one cycle: port 1 wins
    test_fault(3, 8'd128, 5'd0);  // constant data: every read fails, no saturation at 8 bits
    test_ignored_start();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
